rv523_regfile: RTL



---
 rtl/rv523_pkg.sv | 22 ++
 rtl/rv523_reg_word.sv | 28 ++
 rtl/rv523_regfile.sv | 83 ++++++++
 3 files changed

// File: rtl/rv523_pkg.sv
// Shared definitions for the RV523 register files: default sizes, the address-width
// helper and packed read-port bundle types for the integer register file.
package rv523_pkg;

    localparam int unsigned RF_WIDTH = 32;
    localparam int unsigned RF_DEPTH = 32;
    localparam int unsigned RF_NREAD = 2;

    // Also consumed by the decode stage so both agree on x0 and forwarding behaviour.
    localparam bit ZERO_REG_DEFAULT = 1'b1;
    localparam bit BYPASS_DEFAULT   = 1'b1;

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    localparam int unsigned RF_AW = addr_width(RF_DEPTH);

    typedef logic [RF_NREAD-1:0][RF_WIDTH-1:0] rf_rdata_t;
    typedef logic [RF_NREAD-1:0][RF_AW-1:0]    rf_raddr_t;

endpackage

// File: rtl/rv523_reg_word.sv
// One storage word of the register file: synchronous reset, load enable,
// true and complemented outputs.
module rv523_reg_word #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] nQ
);

    logic [WIDTH-1:0] word_q;

    // NOTE: state uses non-blocking assignments only; reset is tested first so it wins over EN.
    always_ff @(posedge CLK) begin
        if (RST) begin
            word_q <= '0;
        end else if (EN) begin
            word_q <= D;
        end
    end

    assign Q  = word_q;
    assign nQ = ~word_q;

endmodule

// File: rtl/rv523_regfile.sv
// Multi-port register file: one synchronous write port, NREAD combinational read
// ports with optional write-to-read bypass and optional hardwired-zero word 0.
module rv523_regfile
    import rv523_pkg::*;
#(
    parameter int unsigned WIDTH    = RF_WIDTH,
    parameter int unsigned DEPTH    = RF_DEPTH,
    parameter int unsigned NREAD    = RF_NREAD,
    parameter bit          ZERO_REG = ZERO_REG_DEFAULT,
    parameter bit          BYPASS   = BYPASS_DEFAULT,
    parameter int unsigned AW       = addr_width(DEPTH)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   WE,
    input  logic [AW-1:0]          WADDR,
    input  logic [WIDTH-1:0]       WDATA,
    input  logic [NREAD*AW-1:0]    RADDR,
    output logic [NREAD*WIDTH-1:0] RDATA,
    output logic [NREAD*WIDTH-1:0] nRDATA
);

    logic [WIDTH-1:0]              word_q [DEPTH];
    logic [WIDTH-1:0]              word_n [DEPTH];
    logic [DEPTH-1:0]              wr_en;
    logic                          wr_ok;
    logic                          wr_hit;
    logic [NREAD-1:0][WIDTH-1:0]   rd_data;
    logic [NREAD-1:0][WIDTH-1:0]   rd_data_n;

    // Widened compare so DEPTH == 2**AW does not wrap to zero.
    assign wr_ok  = (32'(WADDR) < DEPTH) && !(ZERO_REG && (WADDR == '0));
    assign wr_hit = WE && !RST && wr_ok;

    // NOTE: every combinational output gets a default before the loop, so no latch is inferred.
    always_comb begin
        wr_en = '0;
        for (int w = 0; w < DEPTH; w++) begin
            wr_en[w] = WE && wr_ok && (32'(WADDR) == w);
        end
    end

    for (genvar w = 0; w < DEPTH; w++) begin : g_word
        if (ZERO_REG && (w == 0)) begin : g_zero
            assign word_q[w] = '0;
            assign word_n[w] = '1;
        end else begin : g_reg
            rv523_reg_word #(.WIDTH(WIDTH)) u_word (
                .CLK (CLK),
                .RST (RST),
                .EN  (wr_en[w]),
                .D   (WDATA),
                .Q   (word_q[w]),
                .nQ  (word_n[w])
            );
        end
    end

    // Unmatched and out-of-range addresses fall through to the forced-zero default.
    always_comb begin
        logic [AW-1:0] ra;
        rd_data   = '0;
        rd_data_n = '1;
        ra        = '0;
        for (int p = 0; p < NREAD; p++) begin
            ra = RADDR[p*AW +: AW];
            for (int w = 0; w < DEPTH; w++) begin
                if (!(ZERO_REG && (w == 0)) && (32'(ra) == w)) begin
                    rd_data[p]   = word_q[w];
                    rd_data_n[p] = word_n[w];
                end
            end
            if (BYPASS && wr_hit && (ra == WADDR)) begin
                rd_data[p]   = WDATA;
                rd_data_n[p] = ~WDATA;
            end
        end
    end

    assign RDATA  = rd_data;
    assign nRDATA = rd_data_n;

endmodule
